// File: rtl/cpu_pkg.sv
// Shared constants for the Mini-CPU: state and opcode encodings and the default widths.
// The memory bank imports the same package so both ends of the state bus agree.
package cpu_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 4;
  localparam int OP_W        = 3;
  localparam int INSTR_W     = 18;
  localparam int IMM_W_DEF   = 7;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ   = 3'd3,
    ST_CALC   = 3'd4,
    ST_WAIT   = 3'd5,
    ST_STORE  = 3'd6,
    ST_SHOW   = 3'd7
  } cpu_state_e;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD    = 3'd0,
    OP_ADD     = 3'd1,
    OP_ADDI    = 3'd2,
    OP_SUB     = 3'd3,
    OP_SUBI    = 3'd4,
    OP_MUL     = 3'd5,
    OP_CLEAR   = 3'd6,
    OP_DISPLAY = 3'd7
  } opcode_e;

  // LOAD and CLEAR take no operands, so they skip the memory read phase.
  function automatic logic needs_read(opcode_e op);
    return (op != OP_LOAD) && (op != OP_CLEAR);
  endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Memory-side bus between cpu_control (master) and the memory bank (slave).
interface cpu_control_if;
  import cpu_pkg::*;

  logic [2:0]        stateCPU;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;
  logic [DATA_W-1:0] valorGuardarRAM;
  logic [DATA_W-1:0] v1RAM;
  logic [DATA_W-1:0] v2RAM;
  logic              read;
  logic              stored;

  modport master (
    output stateCPU, opcode, addr1, addr2, addr3, valorGuardarRAM,
    input  v1RAM, v2RAM, read, stored
  );

  modport slave (
    input  stateCPU, opcode, addr1, addr2, addr3, valorGuardarRAM,
    output v1RAM, v2RAM, read, stored
  );

endinterface

// File: rtl/cpu_alu.sv
// Combinational result unit: 16-bit two's-complement arithmetic, wrapping mod 2^16.
module cpu_alu
  import cpu_pkg::*;
(
  input  opcode_e           opcode,
  input  logic [DATA_W-1:0] v1,
  input  logic [DATA_W-1:0] v2,
  input  logic [DATA_W-1:0] imm_s,
  output logic [DATA_W-1:0] result
);

  // Select the operation; the 16-bit product keeps only the low half.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result = '0;
    unique case (opcode)
      OP_LOAD:    result = imm_s;
      OP_ADD:     result = v1 + v2;
      OP_ADDI:    result = v1 + imm_s;
      OP_SUB:     result = v1 - v2;
      OP_SUBI:    result = v1 - imm_s;
      OP_MUL:     result = v1 * imm_s;
      OP_CLEAR:   result = '0;
      OP_DISPLAY: result = v1;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Mini-CPU sequencer: latches an instruction on a go edge, walks the shared state bus
// through the memory handshake, computes the result and presents it for display.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int IMM_W   = IMM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               on,
  input  logic               go,
  input  logic [INSTR_W-1:0] instr,
  cpu_control_if.master      bus,
  output logic [DATA_W-1:0]  display_value,
  output logic               display_valid,
  output logic               err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  cpu_state_e        state_q, state_d;
  opcode_e           opcode_q, opcode_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d, addr3_q, addr3_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] disp_value_q, disp_value_d;
  logic              disp_valid_q, disp_valid_d;
  logic              err_q, err_d;
  logic              prev_go_q, prev_go_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              go_edge;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] alu_result;

  assign go_edge = go & ~prev_go_q;
  assign imm_s   = {{(DATA_W - IMM_W){imm_q[IMM_W-1]}}, imm_q};

  cpu_alu u_alu (
    .opcode (opcode_q),
    .v1     (bus.v1RAM),
    .v2     (bus.v2RAM),
    .imm_s  (imm_s),
    .result (alu_result)
  );

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    addr1_d      = addr1_q;
    addr2_d      = addr2_q;
    addr3_d      = addr3_q;
    imm_d        = imm_q;
    result_d     = result_q;
    disp_value_d = disp_value_q;
    disp_valid_d = disp_valid_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    prev_go_d    = go;

    if (!on) begin
      state_d      = ST_OFF;
      disp_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_FETCH;
          err_d   = 1'b0;
        end
        ST_FETCH: begin
          err_d = 1'b0;
          if (go_edge) begin
            opcode_d = opcode_e'(instr[17:15]);
            addr1_d  = instr[14:11];
            addr2_d  = instr[10:7];
            addr3_d  = instr[6:3];
            imm_d    = instr[IMM_W-1:0];
            state_d  = ST_DECODE;
          end
        end
        ST_DECODE: begin
          cnt_d = '0;
          if (opcode_q == OP_LOAD) begin
            state_d = ST_CALC;
          end else if (opcode_q == OP_CLEAR) begin
            // CLEAR bypasses CALC, so its (zero) result is captured here.
            result_d = alu_result;
            state_d  = ST_STORE;
          end else if (needs_read(opcode_q)) begin
            state_d = ST_READ;
          end
        end
        ST_READ, ST_STORE: begin
          if ((state_q == ST_READ) ? bus.read : bus.stored) begin
            if (state_q == ST_READ) begin
              state_d = ST_CALC;
            end else begin
              state_d      = ST_SHOW;
              disp_value_d = result_q;
              disp_valid_d = ~err_q;
            end
          end else if (cnt_q == CNT_LAST) begin
            err_d        = 1'b1;
            state_d      = ST_SHOW;
            disp_value_d = result_q;
            disp_valid_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_CALC: begin
          result_d = alu_result;
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          cnt_d = '0;
          if (opcode_q == OP_DISPLAY) begin
            state_d      = ST_SHOW;
            disp_value_d = result_q;
            disp_valid_d = ~err_q;
          end else begin
            state_d = ST_STORE;
          end
        end
        ST_SHOW: begin
          if (go_edge) begin
            state_d      = ST_FETCH;
            disp_valid_d = 1'b0;
            err_d        = 1'b0;
          end
        end
      endcase
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OFF;
      opcode_q     <= OP_LOAD;
      addr1_q      <= '0;
      addr2_q      <= '0;
      addr3_q      <= '0;
      imm_q        <= '0;
      result_q     <= '0;
      disp_value_q <= '0;
      disp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      prev_go_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      addr1_q      <= addr1_d;
      addr2_q      <= addr2_d;
      addr3_q      <= addr3_d;
      imm_q        <= imm_d;
      result_q     <= result_d;
      disp_value_q <= disp_value_d;
      disp_valid_q <= disp_valid_d;
      err_q        <= err_d;
      prev_go_q    <= prev_go_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.stateCPU        = state_q;
  assign bus.opcode          = opcode_q;
  assign bus.addr1           = addr1_q;
  assign bus.addr2           = addr2_q;
  assign bus.addr3           = addr3_q;
  assign bus.valorGuardarRAM = result_q;
  assign display_value       = disp_value_q;
  assign display_valid       = disp_valid_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: drives the memory flags by hand and checks
// state sequencing, results, timeouts, go-edge handling, power-off and async reset.
module tb_cpu_control;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        on;
  logic        go;
  logic [17:0] instr;
  logic [15:0] display_value;
  logic        display_valid;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_control_if bus ();

  cpu_control #(.TIMEOUT(15), .IMM_W(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .on            (on),
    .go            (go),
    .instr         (instr),
    .bus           (bus),
    .display_value (display_value),
    .display_valid (display_valid),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latch an instruction with a go edge from FETCH (go assumed low beforehand).
  task automatic start(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [6:0] imm, input bit hold_go);
    instr = {op, a, b, imm};
    go    = 1'b1;
    tick();
    if (!hold_go) go = 1'b0;
    instr = 18'h3FFFF;  // later changes must not reach the latched fields
    check("decode_state", 32'(bus.stateCPU), 32'(ST_DECODE));
    check("opcode_latch", 32'(bus.opcode), 32'(op));
    check("addr1_latch", 32'(bus.addr1), 32'(a));
    check("addr2_latch", 32'(bus.addr2), 32'(b));
    check("addr3_latch", 32'(bus.addr3), 32'(imm[6:3]));
  endtask

  // Behave as the memory bank: flags rise one cycle after READ/STORE is entered.
  task automatic run_to_show(output bit saw_store);
    logic [2:0] prev_st;
    prev_st   = 3'(ST_DECODE);
    saw_store = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.stateCPU == 3'(ST_SHOW)) break;
      if (bus.stateCPU == 3'(ST_STORE)) saw_store = 1'b1;
      bus.read   = (bus.stateCPU == 3'(ST_READ))  && (prev_st == 3'(ST_READ));
      bus.stored = (bus.stateCPU == 3'(ST_STORE)) && (prev_st == 3'(ST_STORE));
      prev_st    = bus.stateCPU;
      tick();
    end
    bus.read   = 1'b0;
    bus.stored = 1'b0;
    check("reach_show", 32'(bus.stateCPU), 32'(ST_SHOW));
  endtask

  task automatic leave_show();
    go = 1'b1;
    tick();
    check("show_to_fetch", 32'(bus.stateCPU), 32'(ST_FETCH));
    check("fetch_err_clear", 32'(err), 32'd0);
    check("fetch_valid_clear", 32'(display_valid), 32'd0);
    go = 1'b0;
    tick();
  endtask

  task automatic do_instr(input string tag, input logic [2:0] op, input logic [6:0] imm,
                          input logic [15:0] v1, input logic [15:0] v2,
                          input logic [15:0] exp_val, input bit exp_store);
    bit saw_store;
    $display("[TB] op %s", tag);
    bus.v1RAM = v1;
    bus.v2RAM = v2;
    start(op, 4'd5, 4'd10, imm, 1'b0);
    run_to_show(saw_store);
    check({tag, "_result"}, 32'(bus.valorGuardarRAM), 32'(exp_val));
    check({tag, "_display"}, 32'(display_value), 32'(exp_val));
    check({tag, "_valid"}, 32'(display_valid), 32'd1);
    check({tag, "_store_visit"}, 32'(saw_store), 32'(exp_store));
    leave_show();
  endtask

  initial begin
    int n;
    bit saw_store;

    rst = 1'b1; on = 1'b0; go = 1'b0; instr = '0;
    bus.v1RAM = '0; bus.v2RAM = '0; bus.read = 1'b0; bus.stored = 1'b0;
    #3;
    check("rst_state", 32'(bus.stateCPU), 32'(ST_OFF));
    check("rst_result", 32'(bus.valorGuardarRAM), 32'd0);
    check("rst_display", 32'(display_value), 32'd0);
    check("rst_valid", 32'(display_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_opcode", 32'(bus.opcode), 32'd0);
    rst = 1'b0;
    tick();
    check("off_hold", 32'(bus.stateCPU), 32'(ST_OFF));

    // LOAD a=3 imm=5, stepped by hand.
    on = 1'b1;
    tick();
    check("on_fetch", 32'(bus.stateCPU), 32'(ST_FETCH));
    tick();
    check("fetch_wait", 32'(bus.stateCPU), 32'(ST_FETCH));
    start(3'(OP_LOAD), 4'd3, 4'd1, 7'h05, 1'b0);
    tick();
    check("load_calc", 32'(bus.stateCPU), 32'(ST_CALC));
    tick();
    check("load_wait", 32'(bus.stateCPU), 32'(ST_WAIT));
    check("load_result", 32'(bus.valorGuardarRAM), 32'h0005);
    tick();
    check("load_store", 32'(bus.stateCPU), 32'(ST_STORE));
    tick();
    check("load_store_hold", 32'(bus.stateCPU), 32'(ST_STORE));
    bus.stored = 1'b1;
    tick();
    bus.stored = 1'b0;
    check("load_show", 32'(bus.stateCPU), 32'(ST_SHOW));
    check("load_display", 32'(display_value), 32'h0005);
    check("load_valid", 32'(display_valid), 32'd1);
    check("load_addr1", 32'(bus.addr1), 32'd3);
    go = 1'b1;
    tick();
    check("load_next_fetch", 32'(bus.stateCPU), 32'(ST_FETCH));
    tick();
    check("fetch_held_go", 32'(bus.stateCPU), 32'(ST_FETCH));
    go = 1'b0;
    tick();

    // Operand patterns, results worked out by hand.
    do_instr("add",   3'(OP_ADD),     7'h00, 16'd100,  16'hFFE2, 16'd70,   1'b1);
    do_instr("subi",  3'(OP_SUBI),    7'h7F, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
    do_instr("mul",   3'(OP_MUL),     7'h04, 16'h4000, 16'h0000, 16'h0000, 1'b1);
    do_instr("mulneg",3'(OP_MUL),     7'h7E, 16'h0003, 16'h0000, 16'hFFFA, 1'b1);
    do_instr("sub",   3'(OP_SUB),     7'h00, 16'h0005, 16'h0007, 16'hFFFE, 1'b1);
    do_instr("addi",  3'(OP_ADDI),    7'h40, 16'h0010, 16'h0000, 16'hFFD0, 1'b1);
    do_instr("ldneg", 3'(OP_LOAD),    7'h40, 16'h1111, 16'h2222, 16'hFFC0, 1'b1);
    do_instr("clear", 3'(OP_CLEAR),   7'h00, 16'hABCD, 16'h1234, 16'h0000, 1'b1);
    do_instr("disp",  3'(OP_DISPLAY), 7'h00, 16'h1234, 16'h5678, 16'h1234, 1'b0);

    // READ timeout: read never rises.
    bus.v1RAM = 16'h0042;
    start(3'(OP_SUB), 4'd1, 4'd2, 7'h00, 1'b0);
    tick();
    n = 0;
    while (bus.stateCPU == 3'(ST_READ) && n < 40) begin
      n++;
      tick();
    end
    check("rd_to_cycles", 32'(n), 32'd15);
    check("rd_to_state", 32'(bus.stateCPU), 32'(ST_SHOW));
    check("rd_to_err", 32'(err), 32'd1);
    check("rd_to_valid", 32'(display_valid), 32'd0);
    leave_show();

    // STORE timeout: stored never rises.
    start(3'(OP_LOAD), 4'd2, 4'd0, 7'h11, 1'b0);
    tick(); tick(); tick();
    check("st_to_enter", 32'(bus.stateCPU), 32'(ST_STORE));
    n = 0;
    while (bus.stateCPU == 3'(ST_STORE) && n < 40) begin
      n++;
      tick();
    end
    check("st_to_cycles", 32'(n), 32'd15);
    check("st_to_err", 32'(err), 32'd1);
    check("st_to_valid", 32'(display_valid), 32'd0);
    check("st_to_display", 32'(display_value), 32'h0011);
    leave_show();

    // Go held high from FETCH all the way into SHOW must not retrigger.
    bus.v1RAM = 16'h0BEE;
    start(3'(OP_DISPLAY), 4'd4, 4'd0, 7'h00, 1'b1);
    run_to_show(saw_store);
    tick(); tick();
    check("held_go_show", 32'(bus.stateCPU), 32'(ST_SHOW));
    go = 1'b0;
    tick();
    check("go_low_show", 32'(bus.stateCPU), 32'(ST_SHOW));
    go = 1'b1;
    tick();
    check("second_edge", 32'(bus.stateCPU), 32'(ST_FETCH));
    go = 1'b0;
    tick();

    // Power off while showing: valid clears, value holds.
    bus.v1RAM = 16'h0777;
    start(3'(OP_DISPLAY), 4'd6, 4'd0, 7'h00, 1'b0);
    run_to_show(saw_store);
    on = 1'b0;
    tick();
    check("off_from_show", 32'(bus.stateCPU), 32'(ST_OFF));
    check("off_valid", 32'(display_valid), 32'd0);
    check("off_display_hold", 32'(display_value), 32'h0777);
    on = 1'b1;
    tick();
    check("off_to_fetch", 32'(bus.stateCPU), 32'(ST_FETCH));

    // Power off mid-READ.
    start(3'(OP_ADD), 4'd7, 4'd8, 7'h00, 1'b0);
    tick();
    check("mid_read", 32'(bus.stateCPU), 32'(ST_READ));
    on = 1'b0;
    tick();
    check("off_from_read", 32'(bus.stateCPU), 32'(ST_OFF));
    check("off_opcode_hold", 32'(bus.opcode), 32'(OP_ADD));
    on = 1'b1;
    tick();
    check("reon_fetch", 32'(bus.stateCPU), 32'(ST_FETCH));

    // Async reset in the middle of STORE, between clock edges.
    start(3'(OP_LOAD), 4'd9, 4'd0, 7'h03, 1'b0);
    tick(); tick(); tick();
    check("pre_rst_store", 32'(bus.stateCPU), 32'(ST_STORE));
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(bus.stateCPU), 32'(ST_OFF));
    check("async_rst_result", 32'(bus.valorGuardarRAM), 32'd0);
    check("async_rst_addr1", 32'(bus.addr1), 32'd0);
    check("async_rst_display", 32'(display_value), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_fetch", 32'(bus.stateCPU), 32'(ST_FETCH));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
